// File: rtl/pci_par_err_ctrl_if.sv
// ----------------------------------------------------------------------------
// pci_par_err_ctrl_if
// Bundles the parity-checker strobes, config-space controls and pad-ring
// outputs of the PCI parity-error controller.
//   master : the side that drives checker/config strobes and observes pads
//   slave  : the controller itself
// Signals:
//   new_perrno, new_otperr, new_serrno   raw strobes from the parity checker
//   det_perr_i, sig_serr_i               status set strobes
//   stat_wr_i, stat_wdata_i              status write-1-clear
//   cnt_clr_i, irq_en_i                  counter clear, interrupt enable
//   perr_no_o/perr_oe_o, serr_no_o/serr_oe_o  pad drive values/enables
//   stat_o, err_cnt_o, err_irq_o         status, saturating count, interrupt
// ----------------------------------------------------------------------------
interface pci_par_err_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             new_perrno;
  logic             new_otperr;
  logic             new_serrno;
  logic             det_perr_i;
  logic             sig_serr_i;
  logic             stat_wr_i;
  logic [1:0]       stat_wdata_i;
  logic             cnt_clr_i;
  logic             irq_en_i;
  logic             perr_no_o;
  logic             perr_oe_o;
  logic             serr_no_o;
  logic             serr_oe_o;
  logic [1:0]       stat_o;
  logic [CNT_W-1:0] err_cnt_o;
  logic             err_irq_o;

  modport master (
    output new_perrno, new_otperr, new_serrno, det_perr_i, sig_serr_i,
           stat_wr_i, stat_wdata_i, cnt_clr_i, irq_en_i,
    input  perr_no_o, perr_oe_o, serr_no_o, serr_oe_o, stat_o, err_cnt_o,
           err_irq_o
  );

  modport slave (
    input  new_perrno, new_otperr, new_serrno, det_perr_i, sig_serr_i,
           stat_wr_i, stat_wdata_i, cnt_clr_i, irq_en_i,
    output perr_no_o, perr_oe_o, serr_no_o, serr_oe_o, stat_o, err_cnt_o,
           err_irq_o
  );
endinterface

// File: rtl/pci_par_err_ctrl.sv
// ----------------------------------------------------------------------------
// pci_par_err_ctrl
// Sequences PCI parity-error signalling from the parity checker's raw strobes:
// times PERR# drive/park/release, pulses open-drain SERR#, and keeps sticky
// status bits 15/14, a saturating parity-error counter and an interrupt.
// Ports:
//   clk  PCI clock, rising edge
//   rst  synchronous, active-low reset
//   bus  pci_par_err_ctrl_if.slave (checker strobes, config controls, pads)
// Parameters:
//   CNT_W      width of the saturating error counter
//   SERR_HOLD  cycles SERR# is driven low per request (>= 1)
// ----------------------------------------------------------------------------
module pci_par_err_ctrl #(
  parameter int CNT_W     = 8,
  parameter int SERR_HOLD = 1
) (
  input  logic                clk,
  input  logic                rst,
  pci_par_err_ctrl_if.slave   bus
);

  localparam int HOLD_W = (SERR_HOLD > 1) ? $clog2(SERR_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(SERR_HOLD - 1);

  typedef enum logic [1:0] {
    P_IDLE  = 2'd0,
    P_DRIVE = 2'd1,
    P_PARK  = 2'd2
  } pstate_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  pstate_e          state_q, state_d;
  logic             perr_no_q, perr_no_d;
  logic             otp_q;
  logic             serr_oe_q, serr_oe_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [1:0]       stat_q, stat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             irq_q, irq_d;

  // Stage p0: register everything; otp_q delays the data-phase accept by one
  // cycle so that it lines up with the checker's parity cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= P_IDLE;
      perr_no_q <= 1'b1;
      otp_q     <= 1'b0;
      serr_oe_q <= 1'b0;
      hold_q    <= '0;
      stat_q    <= '0;
      cnt_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      perr_no_q <= perr_no_d;
      otp_q     <= ~bus.new_otperr;
      serr_oe_q <= serr_oe_d;
      hold_q    <= hold_d;
      stat_q    <= stat_d;
      cnt_q     <= cnt_d;
      irq_q     <= irq_d;
    end
  end

  // PERR# next state: any aligned data phase (re)enters DRIVE; otherwise
  // DRIVE parks for one cycle, then releases.
  always_comb begin
    state_d = P_IDLE;
    if (otp_q) begin
      state_d = P_DRIVE;
    end else if (state_q == P_DRIVE) begin
      state_d = P_PARK;
    end
  end

  // PERR# output: checker value while driving, parked high otherwise.
  always_comb begin
    perr_no_d = 1'b1;
    if (otp_q) begin
      perr_no_d = bus.new_perrno;
    end
  end

  // SERR#: each request reloads the hold count, so a request while already
  // driving stretches the pulse.
  always_comb begin
    serr_oe_d = serr_oe_q;
    hold_d    = hold_q;
    if (!bus.new_serrno) begin
      serr_oe_d = 1'b1;
      hold_d    = HOLD_LOAD;
    end else if (hold_q != '0) begin
      hold_d    = hold_q - {{(HOLD_W-1){1'b0}}, 1'b1};
    end else begin
      serr_oe_d = 1'b0;
    end
  end

  // Status, counter, interrupt: set strobes take priority over clears.
  always_comb begin
    stat_d[1] = bus.det_perr_i | (stat_q[1] & ~(bus.stat_wr_i & bus.stat_wdata_i[1]));
    stat_d[0] = bus.sig_serr_i | (stat_q[0] & ~(bus.stat_wr_i & bus.stat_wdata_i[0]));
    irq_d     = bus.irq_en_i & (|stat_d);
    cnt_d     = cnt_q;
    if (bus.cnt_clr_i) begin
      cnt_d = {{(CNT_W-1){1'b0}}, bus.det_perr_i};
    end else if (bus.det_perr_i) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  assign bus.perr_oe_o = (state_q != P_IDLE);
  assign bus.perr_no_o = perr_no_q;
  assign bus.serr_oe_o = serr_oe_q;
  assign bus.serr_no_o = ~serr_oe_q;
  assign bus.stat_o    = stat_q;
  assign bus.err_cnt_o = cnt_q;
  assign bus.err_irq_o = irq_q;

endmodule

// File: tb/tb_pci_par_err_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pci_par_err_ctrl
// Directed scenarios plus randomized traffic, every cycle compared against a
// behavioural model built from phase history and event timestamps.
// ----------------------------------------------------------------------------
module tb_pci_par_err_ctrl;

  localparam int CNT_W     = 8;
  localparam int SERR_HOLD = 1;
  localparam int MAXC      = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pci_par_err_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pci_par_err_ctrl #(.CNT_W(CNT_W), .SERR_HOLD(SERR_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: accept history of the previous two edges, edges since the
  // last SERR request, sticky bits, count, interrupt.
  bit h1, h2;
  bit m_perr_oe, m_perr_no;
  int m_since;
  bit m_b15, m_b14, m_irq;
  int m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    bus.new_otperr   = 1'b1;
    bus.new_perrno   = 1'b1;
    bus.new_serrno   = 1'b1;
    bus.det_perr_i   = 1'b0;
    bus.sig_serr_i   = 1'b0;
    bus.stat_wr_i    = 1'b0;
    bus.stat_wdata_i = 2'b00;
    bus.cnt_clr_i    = 1'b0;
    bus.irq_en_i     = 1'b1;
    rst              = 1'b1;
  endtask

  task automatic model_edge();
    if (!rst) begin
      h1 = 0; h2 = 0; m_perr_oe = 0; m_perr_no = 1;
      m_since = 1000; m_b15 = 0; m_b14 = 0; m_cnt = 0; m_irq = 0;
    end else begin
      // Data phase N shows on PERR# two edges later, parked high one more.
      m_perr_oe = h1 | h2;
      m_perr_no = h1 ? bus.new_perrno : 1'b1;
      h2 = h1;
      h1 = ~bus.new_otperr;
      if (!bus.new_serrno) m_since = 0;
      else if (m_since < 1000) m_since++;
      m_b15 = bus.det_perr_i | (m_b15 & !(bus.stat_wr_i & bus.stat_wdata_i[1]));
      m_b14 = bus.sig_serr_i | (m_b14 & !(bus.stat_wr_i & bus.stat_wdata_i[0]));
      m_irq = bus.irq_en_i & (m_b15 | m_b14);
      if (bus.cnt_clr_i) m_cnt = bus.det_perr_i ? 1 : 0;
      else if (bus.det_perr_i && m_cnt < MAXC) m_cnt++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("perr_oe", 32'(bus.perr_oe_o), 32'(m_perr_oe));
    check("perr_no", 32'(bus.perr_no_o), 32'(m_perr_no));
    check("serr_oe", 32'(bus.serr_oe_o), 32'(m_since < SERR_HOLD));
    check("serr_no", 32'(bus.serr_no_o), 32'(!(m_since < SERR_HOLD)));
    check("stat",    32'(bus.stat_o), {30'd0, m_b15, m_b14});
    check("err_cnt", 32'(bus.err_cnt_o), 32'(m_cnt));
    check("err_irq", 32'(bus.err_irq_o), 32'(m_irq));
  endtask

  int oe_cnt, lo_cnt;

  initial begin
    set_idle();
    rst = 1'b0;
    tick();
    tick();
    check("rst_perr_oe", 32'(bus.perr_oe_o), 32'd0);
    check("rst_perr_no", 32'(bus.perr_no_o), 32'd1);
    check("rst_serr_oe", 32'(bus.serr_oe_o), 32'd0);
    check("rst_stat",    32'(bus.stat_o), 32'd0);
    check("rst_cnt",     32'(bus.err_cnt_o), 32'd0);
    check("rst_irq",     32'(bus.err_irq_o), 32'd0);
    set_idle();
    tick();

    // Single target write with a parity error in the following cycle.
    bus.new_otperr = 1'b0; tick();
    bus.new_otperr = 1'b1; bus.new_perrno = 1'b0; tick();
    check("single_oe_n2", 32'(bus.perr_oe_o), 32'd1);
    check("single_no_n2", 32'(bus.perr_no_o), 32'd0);
    bus.new_perrno = 1'b1; tick();
    check("single_oe_n3", 32'(bus.perr_oe_o), 32'd1);
    check("single_no_n3", 32'(bus.perr_no_o), 32'd1);
    tick();
    check("single_oe_n4", 32'(bus.perr_oe_o), 32'd0);
    repeat (2) tick();

    // Four back-to-back phases, error on the third.
    oe_cnt = 0; lo_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      bus.new_otperr = (i < 4) ? 1'b0 : 1'b1;
      bus.new_perrno = (i == 3) ? 1'b0 : 1'b1;
      tick();
      if (bus.perr_oe_o) oe_cnt++;
      if (bus.perr_oe_o && !bus.perr_no_o) lo_cnt++;
    end
    check("burst_oe_cycles", 32'(oe_cnt), 32'd5);
    check("burst_lo_cycles", 32'(lo_cnt), 32'd1);

    // SERR# pulse widths: single request, then two consecutive requests.
    for (int r = 1; r <= 2; r++) begin
      oe_cnt = 0;
      for (int i = 0; i < 6; i++) begin
        bus.new_serrno = (i < r) ? 1'b0 : 1'b1;
        tick();
        if (bus.serr_oe_o && !bus.serr_no_o) oe_cnt++;
      end
      check("serr_width", 32'(oe_cnt), 32'(r));
    end

    // Set beats simultaneous write-1-clear; clear alone drops bit and irq.
    bus.stat_wr_i = 1'b1; bus.stat_wdata_i = 2'b11; tick();
    bus.det_perr_i = 1'b1; bus.stat_wdata_i = 2'b10; tick();
    check("stat15_set_wins", 32'(bus.stat_o[1]), 32'd1);
    check("irq_set", 32'(bus.err_irq_o), 32'd1);
    bus.det_perr_i = 1'b0; bus.stat_wr_i = 1'b0; tick();
    check("irq_hold", 32'(bus.err_irq_o), 32'd1);
    bus.stat_wr_i = 1'b1; bus.stat_wdata_i = 2'b10; tick();
    check("stat15_clr", 32'(bus.stat_o[1]), 32'd0);
    check("irq_drop", 32'(bus.err_irq_o), 32'd0);
    set_idle();

    // Counter saturation and clear-with-increment.
    bus.det_perr_i = 1'b1;
    repeat (300) tick();
    check("cnt_sat", 32'(bus.err_cnt_o), 32'd255);
    bus.cnt_clr_i = 1'b1; tick();
    check("cnt_clr_inc", 32'(bus.err_cnt_o), 32'd1);
    bus.det_perr_i = 1'b0; tick();
    check("cnt_clr", 32'(bus.err_cnt_o), 32'd0);
    set_idle();

    // Reset in the middle of a burst with SERR# active.
    bus.new_otperr = 1'b0; tick(); tick();
    bus.new_serrno = 1'b0; bus.det_perr_i = 1'b1; bus.sig_serr_i = 1'b1; tick();
    check("pre_rst_perr_oe", 32'(bus.perr_oe_o), 32'd1);
    check("pre_rst_serr_oe", 32'(bus.serr_oe_o), 32'd1);
    rst = 1'b0; tick();
    check("midrst_perr_oe", 32'(bus.perr_oe_o), 32'd0);
    check("midrst_serr_oe", 32'(bus.serr_oe_o), 32'd0);
    check("midrst_stat",    32'(bus.stat_o), 32'd0);
    check("midrst_cnt",     32'(bus.err_cnt_o), 32'd0);
    set_idle();
    tick();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bus.new_otperr   = ($urandom_range(0, 99) < 50) ? 1'b0 : 1'b1;
      bus.new_perrno   = ($urandom_range(0, 99) < 25) ? 1'b0 : 1'b1;
      bus.new_serrno   = ($urandom_range(0, 99) < 15) ? 1'b0 : 1'b1;
      bus.det_perr_i   = ($urandom_range(0, 99) < 30);
      bus.sig_serr_i   = ($urandom_range(0, 99) < 10);
      bus.stat_wr_i    = ($urandom_range(0, 99) < 20);
      bus.stat_wdata_i = 2'($urandom_range(0, 3));
      bus.cnt_clr_i    = ($urandom_range(0, 99) < 3);
      bus.irq_en_i     = ($urandom_range(0, 99) < 80);
      rst              = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
